// File: rtl/imem_responder_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared types and constants for the instruction-fetch responder.
//   - fetch_state_t : responder FSM states
//   - NOP_INSTR     : instruction returned on reset and on any fetch fault
//   - addr_in_range : legal-fetch-window test used on the incoming PC
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RESP
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // True when base <= addr <= base + 2**aw - 1. Done in 64 bits so a window
    // touching the top of the 32-bit space does not wrap.
    function automatic logic addr_in_range(input logic [31:0]  addr,
                                           input logic [31:0]  base,
                                           input int unsigned  aw);
        logic [63:0] off;
        off = {32'd0, addr} - {32'd0, base};
        return (addr >= base) && ((off >> aw) == 64'd0);
    endfunction

endpackage

// File: rtl/imem_responder_hit_buf.sv
// ---------------------------------------------------------------------------
// imem_hit_buf
//   One-entry {valid, addr, instr} buffer remembering the last good fetch.
//   Only compiled when IMEM_HIT_BUF_EN is defined.
// Ports
//   clk, nRST    : clock (rising edge), asynchronous active-low reset
//   lookup_addr  : address to test against the stored tag
//   hit          : entry valid and tag equals lookup_addr
//   hit_instr    : stored instruction word
//   wr_en        : store {wr_addr, wr_instr} and mark valid
//   wr_addr      : tag to store
//   wr_instr     : instruction to store
//   inv          : clear the valid bit (takes priority over wr_en)
// ---------------------------------------------------------------------------
`ifdef IMEM_HIT_BUF_EN
module imem_hit_buf (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] lookup_addr,
    output logic        hit,
    output logic [31:0] hit_instr,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_instr,
    input  logic        inv
);
    import cpu_pkg::*;

    logic        valid_q, valid_d;
    logic [31:0] tag_q,   tag_d;
    logic [31:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (inv) begin
            valid_d = 1'b0;
        end else if (wr_en) begin
            valid_d = 1'b1;
            tag_d   = wr_addr;
            data_d  = wr_instr;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit       = valid_q && (tag_q == lookup_addr);
    assign hit_instr = data_q;

endmodule
`endif

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//   Responder side of the instruction-fetch handshake. Latches the PC word
//   address, reads four bytes from a byte-wide memory, assembles them
//   little-endian and returns the word with a one-cycle iready pulse.
//   Misaligned / out-of-range PCs and memory timeouts return NOP with ifault.
//   Optional one-entry hit buffer: define IMEM_HIT_BUF_EN.
// Parameters
//   MEM_AW      : byte-address width of the memory port
//   TIMEOUT_CYC : max cycles waiting for mem_rvalid on one byte
//   BASE_ADDR   : lowest legal fetch address (window is 2**MEM_AW bytes)
// Ports
//   clk, nRST   : clock (rising edge), asynchronous active-low reset
//   PCaddr      : fetch address from the PC (held until after iready)
//   iready      : one-cycle pulse, instr/ifault valid
//   instr       : fetched instruction, holds between pulses
//   ifault      : fetch fault, valid with iready
//   mem_ren     : byte read request, held until mem_rvalid sampled
//   mem_addr    : byte address, stable while mem_ren=1
//   mem_rdata   : read byte, valid with mem_rvalid
//   mem_rvalid  : read data valid (may coincide with the first mem_ren cycle)
// ---------------------------------------------------------------------------
module imem_responder
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_AW      = 16,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic [31:0]       PCaddr,
    output logic              iready,
    output logic [31:0]       instr,
    output logic              ifault,
    output logic              mem_ren,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid
);

    localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    fetch_state_t    state_q,   state_d;
    logic [31:0]     addr_q,    addr_d;
    logic [1:0]      cnt_q,     cnt_d;
    logic [TO_W-1:0] tcnt_q,    tcnt_d;
    logic [23:0]     asm_q,     asm_d;
    logic [31:0]     instr_q,   instr_d;
    logic            ifault_q,  ifault_d;
    logic            iready_q,  iready_d;
    logic            mem_ren_q, mem_ren_d;

    logic            buf_wr;
    logic            buf_inv;
    logic            hit;
    logic [31:0]     hit_instr;
    logic [31:0]     fetch_word;

    // The last byte goes straight into the output word; only bytes 0..2
    // need to be parked in the assembly register.
    assign fetch_word = {mem_rdata, asm_q};

`ifdef IMEM_HIT_BUF_EN
    imem_hit_buf u_hit_buf (
        .clk         (clk),
        .nRST        (nRST),
        .lookup_addr (PCaddr),
        .hit         (hit),
        .hit_instr   (hit_instr),
        .wr_en       (buf_wr),
        .wr_addr     (addr_q),
        .wr_instr    (fetch_word),
        .inv         (buf_inv)
    );
`else
    logic buf_unused;
    assign hit        = 1'b0;
    assign hit_instr  = NOP_INSTR;
    assign buf_unused = buf_wr ^ buf_inv;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        asm_d     = asm_q;
        instr_d   = instr_q;
        ifault_d  = ifault_q;
        iready_d  = 1'b0;
        mem_ren_d = 1'b0;
        buf_wr    = 1'b0;
        buf_inv   = 1'b0;

        unique case (state_q)
            IDLE: begin
                addr_d = PCaddr;
                cnt_d  = '0;
                tcnt_d = '0;
                if ((PCaddr[1:0] != 2'b00) || !addr_in_range(PCaddr, BASE_ADDR, MEM_AW)) begin
                    state_d  = RESP;
                    iready_d = 1'b1;
                    ifault_d = 1'b1;
                    instr_d  = NOP_INSTR;
                    buf_inv  = 1'b1;
                end else if (hit) begin
                    state_d  = RESP;
                    iready_d = 1'b1;
                    ifault_d = 1'b0;
                    instr_d  = hit_instr;
                end else begin
                    state_d   = FETCH;
                    mem_ren_d = 1'b1;
                end
            end

            FETCH: begin
                // A moved PC means the requester gave up on this fetch.
                if (PCaddr != addr_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                end else if (mem_rvalid) begin
                    tcnt_d = '0;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d  = RESP;
                        iready_d = 1'b1;
                        ifault_d = 1'b0;
                        instr_d  = fetch_word;
                        buf_wr   = 1'b1;
                    end else begin
                        mem_ren_d = 1'b1;
                        case (cnt_q)
                            2'd0:    asm_d[7:0]   = mem_rdata;
                            2'd1:    asm_d[15:8]  = mem_rdata;
                            default: asm_d[23:16] = mem_rdata;
                        endcase
                    end
                end else if (tcnt_q == TO_LAST) begin
                    state_d  = RESP;
                    iready_d = 1'b1;
                    ifault_d = 1'b1;
                    instr_d  = NOP_INSTR;
                    buf_inv  = 1'b1;
                end else begin
                    tcnt_d    = tcnt_q + 1'b1;
                    mem_ren_d = 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            asm_q     <= '0;
            instr_q   <= NOP_INSTR;
            ifault_q  <= 1'b0;
            iready_q  <= 1'b0;
            mem_ren_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            asm_q     <= asm_d;
            instr_q   <= instr_d;
            ifault_q  <= ifault_d;
            iready_q  <= iready_d;
            mem_ren_q <= mem_ren_d;
        end
    end

    assign iready   = iready_q;
    assign instr    = instr_q;
    assign ifault   = ifault_q;
    assign mem_ren  = mem_ren_q;
    assign mem_addr = addr_q[MEM_AW-1:0] + MEM_AW'(cnt_q);

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
//   Directed bench for imem_responder (MEM_AW=16, TIMEOUT_CYC=8, BASE=0).
//   A byte memory with programmable wait states answers mem_ren; a
//   transaction-level model predicts when iready must pulse and with which
//   instr/ifault, and a negedge process compares every cycle.
//   Build with IMEM_HIT_BUF_EN defined to exercise the hit buffer.
// ---------------------------------------------------------------------------
module tb_imem_responder;

    localparam int          TO  = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IMEM_HIT_BUF_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] PCaddr = 32'h0;
    logic        iready;
    logic [31:0] instr;
    logic        ifault;
    logic        mem_ren;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_rvalid = 1'b0;

    imem_responder #(
        .MEM_AW      (16),
        .TIMEOUT_CYC (TO),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clk        (clk),
        .nRST       (nRST),
        .PCaddr     (PCaddr),
        .iready     (iready),
        .instr      (instr),
        .ifault     (ifault),
        .mem_ren    (mem_ren),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- byte memory with wait states ----------------
    logic [7:0]  mem [0:65535];
    int          waits = 0;
    bit          stuck = 1'b0;
    bit          noise = 1'b0;
    int          wcnt = 0;
    bit          prev_ren = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    logic [15:0] log_q[$];

    always begin
        @(posedge clk);
        #1;
        if (mem_ren) begin
            log_q.push_back(mem_addr);
            if (!prev_ren || mem_addr != prev_addr) wcnt = 0;
            else wcnt++;
            mem_rvalid = !stuck && (wcnt >= waits);
            mem_rdata  = mem_rvalid ? mem[mem_addr] : 8'h5A;
        end else begin
            mem_rvalid = noise;
            mem_rdata  = 8'hEE;
        end
        prev_ren  = mem_ren;
        prev_addr = mem_addr;
    end

    // ---------------- transaction model ----------------
    typedef struct {
        int          cyc;
        logic [31:0] instr;
        logic        fault;
        bit          no_ren;
    } exp_t;

    exp_t        exq[$];
    logic [31:0] m_instr = NOP;
    int          last_rdy_cyc = -1;
    logic        last_fault = 1'b0;
    bit          mb_valid = 1'b0;
    logic [31:0] mb_addr = 32'h0;
    logic [31:0] mb_instr = 32'h0;
    bit          pulse;

    function automatic logic [31:0] word_at(input logic [15:0] a);
        return {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
    endfunction

    always @(negedge clk) begin
        if (!nRST) begin
            chk("rst_iready",  32'(iready),  32'h0);
            chk("rst_ifault",  32'(ifault),  32'h0);
            chk("rst_instr",   instr,        NOP);
            chk("rst_mem_ren", 32'(mem_ren), 32'h0);
        end else begin
            pulse = (exq.size() > 0) && (exq[0].cyc == cyc);
            chk("iready", 32'(iready), 32'(pulse));
            if (pulse) begin
                chk("instr",        instr,         exq[0].instr);
                chk("ifault",       32'(ifault),   32'(exq[0].fault));
                chk("resp_mem_ren", 32'(mem_ren),  32'h0);
                m_instr      = exq[0].instr;
                last_rdy_cyc = cyc;
                last_fault   = ifault;
                void'(exq.pop_front());
            end else begin
                chk("instr_hold", instr, m_instr);
                if (exq.size() > 0 && exq[0].no_ren)
                    chk("no_mem_ren", 32'(mem_ren), 32'h0);
            end
        end
    end

    // Called in the cycle the DUT is idle; PCaddr set here is sampled at
    // the end of this cycle. Returns in the idle cycle after the response.
    task automatic do_fetch(input logic [31:0] a, input int w, input bit stk);
        int          lat;
        int          bad;
        exp_t        e;
        e.cyc   = cyc;
        PCaddr  = a;
        waits   = w;
        stuck   = stk;
        log_q.delete();
        if (a[1:0] != 2'b00 || !(a < 32'h0001_0000)) begin
            lat = 1; e.instr = NOP; e.fault = 1'b1; e.no_ren = 1'b1;
            mb_valid = 1'b0;
        end else if (HB && mb_valid && mb_addr == a) begin
            lat = 1; e.instr = mb_instr; e.fault = 1'b0; e.no_ren = 1'b1;
        end else if (stk) begin
            lat = TO + 1; e.instr = NOP; e.fault = 1'b1; e.no_ren = 1'b0;
            mb_valid = 1'b0;
        end else begin
            lat = 1 + 4 * (w + 1); e.instr = word_at(a[15:0]); e.fault = 1'b0; e.no_ren = 1'b0;
            mb_valid = 1'b1; mb_addr = a; mb_instr = e.instr;
        end
        e.cyc = e.cyc + lat;
        exq.push_back(e);
        repeat (lat + 1) @(posedge clk);
        #1;
        chk("resp_seen", 32'(exq.size()), 32'h0);
        exq.delete();
        bad = 0;
        if (e.no_ren) begin
            chk("addr_log_len", 32'(log_q.size()), 32'h0);
        end else if (stk) begin
            chk("addr_log_len", 32'(log_q.size()), 32'(TO));
            foreach (log_q[i]) if (log_q[i] != a[15:0]) bad++;
            chk("addr_log_seq", 32'(bad), 32'h0);
        end else begin
            chk("addr_log_len", 32'(log_q.size()), 32'(4 * (w + 1)));
            foreach (log_q[i]) if (log_q[i] != 16'(a[15:0] + 16'(i / (w + 1)))) bad++;
            chk("addr_log_seq", 32'(bad), 32'h0);
        end
    endtask

    int c0;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("init_iready",  32'(iready),  32'h0);
        chk("init_instr",   instr,        32'h0000_0013);
        chk("init_mem_ren", 32'(mem_ren), 32'h0);
        nRST = 1'b1;

        // zero-wait fetch from 0
        c0 = cyc;
        do_fetch(32'h0, 0, 1'b0);
        chk("t1_latency", 32'(last_rdy_cyc - c0), 32'd5);
        chk("t1_instr",   instr,                  32'h0000_0513);
        chk("t1_ifault",  32'(last_fault),        32'h0);

        // three wait states per byte
        c0 = cyc;
        do_fetch(32'h4, 3, 1'b0);
        chk("t2_latency", 32'(last_rdy_cyc - c0), 32'd17);
        chk("t2_instr",   instr,                  32'h342D_261F);

        // misaligned, with rvalid noise while idle
        noise = 1'b1;
        c0 = cyc;
        do_fetch(32'h2, 0, 1'b0);
        chk("t3_latency", 32'(last_rdy_cyc - c0), 32'd1);
        chk("t3_instr",   instr,                  32'h0000_0013);
        chk("t3_ifault",  32'(last_fault),        32'h1);

        // rvalid never comes
        c0 = cyc;
        do_fetch(32'h8, 0, 1'b1);
        chk("t4_latency", 32'(last_rdy_cyc - c0), 32'd9);
        chk("t4_ifault",  32'(last_fault),        32'h1);

        // range edges
        do_fetch(32'h0001_0000, 0, 1'b0);
        chk("oor_ifault", 32'(last_fault), 32'h1);
        do_fetch(32'hFFFF_FFFC, 0, 1'b0);
        do_fetch(32'h0000_FFFC, 1, 1'b0);
        chk("top_word_ifault", 32'(last_fault), 32'h0);
        do_fetch(32'h0000_0C01, 0, 1'b0);

        // PC moves mid-fetch: no response for 0x10, fresh fetch of 0x14
        PCaddr = 32'h10; waits = 1; stuck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        PCaddr = 32'h14;
        @(posedge clk);
        #1;
        c0 = cyc;
        do_fetch(32'h14, 1, 1'b0);
        chk("abort_latency", 32'(last_rdy_cyc - c0), 32'd9);

        // same PC twice
        do_fetch(32'h4, 0, 1'b0);
        c0 = cyc;
        do_fetch(32'h4, 0, 1'b0);
        chk("repeat_latency", 32'(last_rdy_cyc - c0), HB ? 32'd1 : 32'd5);
        chk("repeat_instr",   instr,                  32'h342D_261F);

        // reset while byte 2 is being read
        PCaddr = 32'h8; waits = 0; stuck = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nRST = 1'b0;
        exq.delete();
        m_instr  = NOP;
        mb_valid = 1'b0;
        #1;
        chk("mid_rst_iready",  32'(iready),  32'h0);
        chk("mid_rst_ifault",  32'(ifault),  32'h0);
        chk("mid_rst_instr",   instr,        32'h0000_0013);
        chk("mid_rst_mem_ren", 32'(mem_ren), 32'h0);
        @(posedge clk);
        #1;
        nRST = 1'b1;
        c0 = cyc;
        do_fetch(32'h20, 0, 1'b0);
        chk("post_rst_latency", 32'(last_rdy_cyc - c0), 32'd5);
        c0 = cyc;
        do_fetch(32'h20, 2, 1'b0);
        chk("post_rst_repeat", 32'(last_rdy_cyc - c0), HB ? 32'd1 : 32'd13);
        do_fetch(32'h2, 0, 1'b0);
        c0 = cyc;
        do_fetch(32'h20, 0, 1'b0);
        chk("after_fault_latency", 32'(last_rdy_cyc - c0), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
